// File: rtl/iob_priority_encoder.sv
// iob_priority_encoder: binary index of the winning set bit, lowest or highest index first.
module iob_priority_encoder #(
    parameter int WIDTH        = 4,
    parameter     LSB_PRIORITY = "LOW",
    localparam int W = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] unencoded_i,
    output logic [W-1:0]     encoded_o,
    output logic             valid_o
);
    always_comb begin
        encoded_o = '0;
        valid_o   = |unencoded_i;
        if (LSB_PRIORITY == "LOW") begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (unencoded_i[i]) encoded_o = W'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (unencoded_i[i]) encoded_o = W'(i);
        end
    end
endmodule

// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter: round-robin arbiter; a grant is held until its ack or request withdrawal,
// and the next winner is chosen in the release cycle so grants run back-to-back.
module iob_rr_arbiter #(
    parameter int N_PORTS      = 4,
    parameter     LSB_PRIORITY = "LOW",
    localparam int W = N_PORTS > 1 ? $clog2(N_PORTS) : 1
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               cke_i,
    input  logic [N_PORTS-1:0] req_i,
    input  logic [N_PORTS-1:0] ack_i,
    output logic [N_PORTS-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [W-1:0]       grant_encoded_o
);
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;
    // Reset points last_idx at the far end so the first pass starts at the preferred end
    localparam logic [W-1:0] LAST_RST = LSB_PRIORITY == "LOW" ? W'(N_PORTS - 1) : '0;

    logic               state_q, state_d;
    logic [W-1:0]       last_q, last_d;
    logic [N_PORTS-1:0] mask_req, grant_d;
    logic               valid_d, rel, mvalid, rvalid;
    logic [W-1:0]       enc_d, menc, renc, win;

    always_comb begin
        rel    = state_q == BUSY && (ack_i[grant_encoded_o] || !req_i[grant_encoded_o]);
        last_d = rel ? grant_encoded_o : last_q;
        for (int i = 0; i < N_PORTS; i++)
            mask_req[i] = req_i[i] && (LSB_PRIORITY == "LOW" ? i > int'(last_d) : i < int'(last_d));
    end

    iob_priority_encoder #(.WIDTH(N_PORTS), .LSB_PRIORITY(LSB_PRIORITY)) u_mask_enc (
        .unencoded_i(mask_req),
        .encoded_o  (menc),
        .valid_o    (mvalid)
    );

    iob_priority_encoder #(.WIDTH(N_PORTS), .LSB_PRIORITY(LSB_PRIORITY)) u_req_enc (
        .unencoded_i(req_i),
        .encoded_o  (renc),
        .valid_o    (rvalid)
    );

    always_comb begin
        win     = mvalid ? menc : renc;
        state_d = state_q;
        grant_d = grant_o;
        valid_d = grant_valid_o;
        enc_d   = grant_encoded_o;
        if (state_q == IDLE || rel) begin
            state_d = rvalid ? BUSY : IDLE;
            grant_d = '0;
            if (rvalid) grant_d[win] = 1'b1;
            valid_d = rvalid;
            enc_d   = rvalid ? win : '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= IDLE;
        else if (cke_i) state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            grant_o         <= '0;
            grant_valid_o   <= 1'b0;
            grant_encoded_o <= '0;
        end else if (cke_i) begin
            grant_o         <= grant_d;
            grant_valid_o   <= valid_d;
            grant_encoded_o <= enc_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) last_q <= LAST_RST;
        else if (cke_i) last_q <= last_d;
    end
endmodule
